sdram_func_module: RTL

SDRAM_FUNC_MODULE -- requirements
Module: sdram_func_module

---
 rtl/sdram_pkg.sv | 24 ++
 rtl/sdram_if.sv | 10 +
 rtl/sdram_delay_cnt.sv | 15 +
 rtl/sdram_func_module.sv | 121 ++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// sdram_pkg: command encodings, FSM states and default timing for the SDRAM function engine
package sdram_pkg;
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_REF  = 4'b0001;
  localparam logic [3:0] CMD_LMR  = 4'b0000;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_DESL = 4'b1111;
  localparam int DEF_T_PWRUP = 20000;
  localparam int DEF_T_RP    = 3;
  localparam int DEF_T_RFC   = 7;
  localparam int DEF_T_MRD   = 2;
  localparam int DEF_T_RCD   = 3;
  localparam int DEF_T_WR    = 2;
  localparam int DEF_CL      = 3;
  localparam logic [11:0] DEF_MODE_REG = 12'h030;
  localparam int CNT_W = 15;
  typedef enum logic [3:0] {
    S_IDLE, S_INIT_WAIT, S_PRE, S_REF1, S_REF2, S_LMR, S_ACT, S_WR, S_RD, S_WAIT, S_DONE
  } state_t;
  typedef enum logic [1:0] {OP_INIT, OP_REF, OP_WR, OP_RD} op_t;
endpackage

// File: rtl/sdram_if.sv
// sdram_if: caller-side request/completion handshake of the SDRAM function engine
interface sdram_if;
  logic [3:0]  iCall;
  logic [21:0] iAddr;
  logic [15:0] iWrData;
  logic        oDone;
  logic [15:0] oRdData;
  modport master(output iCall, iAddr, iWrData, input oDone, oRdData);
  modport slave(input iCall, iAddr, iWrData, output oDone, oRdData);
endinterface

// File: rtl/sdram_delay_cnt.sv
// sdram_delay_cnt: loadable down-counter that stops at zero and flags it
module sdram_delay_cnt #(parameter int W = 15) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk)
    if (!rst_n) r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  assign o_zero = r_cnt == '0;
endmodule

// File: rtl/sdram_func_module.sv
// sdram_func_module: one-request-at-a-time SDRAM engine for init, refresh, single-word write and read
module sdram_func_module import sdram_pkg::*; #(
  parameter int T_PWRUP = DEF_T_PWRUP,
  parameter int T_RP    = DEF_T_RP,
  parameter int T_RFC   = DEF_T_RFC,
  parameter int T_MRD   = DEF_T_MRD,
  parameter int T_RCD   = DEF_T_RCD,
  parameter int T_WR    = DEF_T_WR,
  parameter int CL      = DEF_CL,
  parameter logic [11:0] MODE_REG = DEF_MODE_REG
) (
  input  logic        clk,
  input  logic        rst_n,
  sdram_if.slave      host,
  output logic        oSDR_CKE,
  output logic        oSDR_CS_N,
  output logic        oSDR_RAS_N,
  output logic        oSDR_CAS_N,
  output logic        oSDR_WE_N,
  output logic [1:0]  oSDR_BA,
  output logic [11:0] oSDR_ADDR,
  output logic [1:0]  oSDR_DQM,
  inout  wire  [15:0] ioSDR_DQ
);
  state_t r_state, w_next, r_ret, w_ret, w_tgt;
  op_t r_op, w_op;
  logic r_init_done, w_load, w_zero;
  logic [CNT_W-1:0] w_val, w_dly;
  logic [21:0] r_addr;
  logic [15:0] r_wdata, r_rd;
  logic [3:0] w_cmd;
  sdram_delay_cnt #(.W(CNT_W)) u_cnt (
    .clk(clk), .rst_n(rst_n), .i_load(w_load), .i_val(w_val), .o_zero(w_zero)
  );
  // Every command state names its delay and successor; the shared WAIT state burns delay-1 cycles.
  always_comb begin
    w_next = r_state;
    w_ret = r_ret;
    w_op = r_op;
    w_load = 1'b0;
    w_val = '0;
    w_dly = '0;
    w_tgt = S_IDLE;
    case (r_state)
      S_IDLE:
        if (host.iCall[3]) begin
          w_next = S_INIT_WAIT;
          w_op = OP_INIT;
          w_load = 1'b1;
          w_val = CNT_W'(T_PWRUP - 1);
        end else if (r_init_done && host.iCall[2]) begin
          w_next = S_PRE;
          w_op = OP_REF;
        end else if (r_init_done && host.iCall[1]) begin
          w_next = S_ACT;
          w_op = OP_WR;
        end else if (r_init_done && host.iCall[0]) begin
          w_next = S_ACT;
          w_op = OP_RD;
        end
      S_INIT_WAIT: w_next = w_zero ? S_PRE : S_INIT_WAIT;
      S_PRE: begin w_dly = CNT_W'(T_RP); w_tgt = S_REF1; end
      S_REF1: begin w_dly = CNT_W'(T_RFC); w_tgt = r_op == OP_INIT ? S_REF2 : S_DONE; end
      S_REF2: begin w_dly = CNT_W'(T_RFC); w_tgt = S_LMR; end
      S_LMR: begin w_dly = CNT_W'(T_MRD); w_tgt = S_DONE; end
      S_ACT: begin w_dly = CNT_W'(T_RCD); w_tgt = r_op == OP_WR ? S_WR : S_RD; end
      S_WR: begin w_dly = CNT_W'(T_WR + T_RP); w_tgt = S_DONE; end
      S_RD: begin w_dly = CNT_W'(CL + 1); w_tgt = S_DONE; end
      S_WAIT: w_next = w_zero ? r_ret : S_WAIT;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_dly != '0) begin
      w_next = S_WAIT;
      w_ret = w_tgt;
      w_load = 1'b1;
      w_val = w_dly - CNT_W'(2);
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ret <= S_IDLE;
      r_op <= OP_INIT;
      r_init_done <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_rd <= '0;
    end else begin
      r_state <= w_next;
      r_ret <= w_ret;
      r_op <= w_op;
      if (r_state == S_DONE && r_op == OP_INIT) r_init_done <= 1'b1;
      if (r_state == S_IDLE && w_next != S_IDLE) begin
        r_addr <= host.iAddr;
        r_wdata <= host.iWrData;
      end
      // Last cycle of the post-READ wait is CAS latency after the READ command.
      if (r_state == S_WAIT && r_ret == S_DONE && r_op == OP_RD && w_zero) r_rd <= ioSDR_DQ;
    end
  always_comb begin
    w_cmd = (r_state == S_IDLE && !r_init_done) ? CMD_DESL : CMD_NOP;
    w_cmd = r_state == S_PRE ? CMD_PRE :
            (r_state == S_REF1 || r_state == S_REF2) ? CMD_REF :
            r_state == S_LMR ? CMD_LMR :
            r_state == S_ACT ? CMD_ACT :
            r_state == S_WR ? CMD_WR :
            r_state == S_RD ? CMD_RD : w_cmd;
    oSDR_BA = (r_state == S_ACT || r_state == S_WR || r_state == S_RD) ? r_addr[21:20] : 2'b00;
    oSDR_ADDR = r_state == S_PRE ? 12'h400 :
                r_state == S_LMR ? MODE_REG :
                r_state == S_ACT ? r_addr[19:8] :
                (r_state == S_WR || r_state == S_RD) ? {4'b0100, r_addr[7:0]} : 12'h000;
  end
  assign {oSDR_CS_N, oSDR_RAS_N, oSDR_CAS_N, oSDR_WE_N} = w_cmd;
  assign oSDR_CKE = !(r_state == S_IDLE && !r_init_done);
  assign oSDR_DQM = r_init_done ? 2'b00 : 2'b11;
  assign ioSDR_DQ = r_state == S_WR ? r_wdata : 16'hzzzz;
  assign host.oDone = r_state == S_DONE;
  assign host.oRdData = r_rd;
endmodule
